// File: rtl/udp_ipv4_rx_parse.sv
// Receive-side IPv4/UDP header parser: checks the 7 header beats, publishes sender metadata,
// and forwards the UDP payload through a 1-deep output register.
module udp_ipv4_rx_parse #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        clk_32,
  input  logic        reset_32,
  input  logic [31:0] axis_tdata_in,
  input  logic [3:0]  axis_tkeep_in,
  input  logic        axis_tvalid_in,
  input  logic        axis_tlast_in,
  output logic        axis_tready_out,
  output logic [31:0] axis_tdata_out,
  output logic [3:0]  axis_tkeep_out,
  output logic        axis_tvalid_out,
  output logic        axis_tfirst_out,
  output logic        axis_tlast_out,
  input  logic        axis_tready_in,
  output logic        meta_valid,
  output logic [31:0] meta_src_ip,
  output logic [15:0] meta_src_port,
  output logic [15:0] meta_udp_len,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t      state;
  logic [2:0]  hdr_idx;
  logic        fail_flag;
  logic        first_pend;
  logic [31:0] src_ip_q;
  logic [15:0] src_port_q;
  logic        accept;
  logic        beat_fail;
  logic        fail_any;

  // Payload may enter while the held output beat drains this cycle.
  assign axis_tready_out = !reset_32 &&
                           ((state != S_PAYLOAD) || axis_tready_in || !axis_tvalid_out);
  assign accept = axis_tvalid_in && axis_tready_out;

  always_comb begin
    beat_fail = (axis_tkeep_in != 4'hF) || (axis_tlast_in && (hdr_idx != 3'd6));
    case (hdr_idx)
      3'd0: if (axis_tdata_in[31:28] != 4'd4 || axis_tdata_in[27:24] != 4'd5) beat_fail = 1'b1;
      3'd1: if (axis_tdata_in[13:0] != '0) beat_fail = 1'b1;
      3'd2: if (axis_tdata_in[23:16] != 8'h11) beat_fail = 1'b1;
      3'd4: if (axis_tdata_in != LOCAL_IP) beat_fail = 1'b1;
      3'd5: if (axis_tdata_in[15:0] != LOCAL_PORT) beat_fail = 1'b1;
      default: ;
    endcase
    fail_any = fail_flag || beat_fail;
  end

  always_ff @(posedge clk_32) begin
    if (reset_32) begin
      state           <= S_HDR;
      hdr_idx         <= '0;
      fail_flag       <= 1'b0;
      first_pend      <= 1'b0;
      src_ip_q        <= '0;
      src_port_q      <= '0;
      axis_tdata_out  <= '0;
      axis_tkeep_out  <= '0;
      axis_tvalid_out <= 1'b0;
      axis_tfirst_out <= 1'b0;
      axis_tlast_out  <= 1'b0;
      meta_valid      <= 1'b0;
      meta_src_ip     <= '0;
      meta_src_port   <= '0;
      meta_udp_len    <= '0;
      good_cnt        <= '0;
      drop_cnt        <= '0;
    end else begin
      meta_valid <= 1'b0;
      if (axis_tvalid_out && axis_tready_in) begin
        axis_tvalid_out <= 1'b0;
        axis_tkeep_out  <= '0;
        axis_tlast_out  <= 1'b0;
        axis_tfirst_out <= 1'b0;
      end

      case (state)
        S_HDR: begin
          if (accept) begin
            if (fail_any) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              fail_flag <= 1'b0;
              hdr_idx   <= '0;
              state     <= axis_tlast_in ? S_HDR : S_DROP;
            end else if (hdr_idx == 3'd6) begin
              meta_valid    <= 1'b1;
              meta_src_ip   <= src_ip_q;
              meta_src_port <= src_port_q;
              meta_udp_len  <= axis_tdata_in[31:16];
              if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
              fail_flag  <= 1'b0;
              hdr_idx    <= '0;
              first_pend <= 1'b1;
              state      <= axis_tlast_in ? S_HDR : S_PAYLOAD;
            end else begin
              fail_flag <= fail_any;
              hdr_idx   <= hdr_idx + 3'd1;
              if (hdr_idx == 3'd3) src_ip_q   <= axis_tdata_in;
              if (hdr_idx == 3'd5) src_port_q <= axis_tdata_in[31:16];
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            axis_tdata_out  <= axis_tdata_in;
            axis_tkeep_out  <= axis_tkeep_in;
            axis_tlast_out  <= axis_tlast_in;
            axis_tfirst_out <= first_pend;
            axis_tvalid_out <= 1'b1;
            first_pend      <= 1'b0;
            if (axis_tlast_in) state <= S_HDR;
          end
        end
        S_DROP: begin
          if (accept && axis_tlast_in) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
